// File: rtl/mips_debug_ctrl.sv
// Debug/loader controller between a byte-stream host link and the MIPS pipeline.
// Loads instruction words into memory, then runs the pipeline continuously or stepwise.
module mips_debug_ctrl #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         CNT_WIDTH   = 32,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_halt,
    output logic                  o_inst_wr_en,
    output logic [ADDR_WIDTH-1:0] o_inst_addr,
    output logic [DATA_WIDTH-1:0] o_inst_data,
    output logic                  o_pipe_reset,
    output logic                  o_pipe_enable,
    output logic [CNT_WIDTH-1:0]  o_cycle_count,
    output logic                  o_load_overflow,
    output logic                  o_finish,
    output logic [2:0]            o_state
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_R = 8'h52;

    localparam logic [IDXW-1:0]       IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0]       IDX_LAST = IDXW'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_READY    = 3'd2,
        S_RUN_CONT = 3'd3,
        S_RUN_STEP = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_word;
    logic [IDXW-1:0]       r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_inst_wr_en;
    logic [ADDR_WIDTH-1:0] r_inst_addr;
    logic [DATA_WIDTH-1:0] r_inst_data;
    logic                  r_pipe_reset;
    logic                  r_pipe_enable;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic                  r_load_overflow;
    logic                  r_finish;

    logic                  w_cmd_l;
    logic                  w_cmd_c;
    logic                  w_cmd_s;
    logic                  w_cmd_n;
    logic                  w_cmd_r;
    logic                  w_last_byte;
    logic                  w_wr_halt;
    logic                  w_wr_last_addr;
    logic                  w_load_exit;
    logic                  w_cnt_sat;
    logic [DATA_WIDTH-1:0] w_word_next;

    assign w_cmd_l = i_rx_valid && (i_rx_data == CMD_L);
    assign w_cmd_c = i_rx_valid && (i_rx_data == CMD_C);
    assign w_cmd_s = i_rx_valid && (i_rx_data == CMD_S);
    assign w_cmd_n = i_rx_valid && (i_rx_data == CMD_N);
    assign w_cmd_r = i_rx_valid && (i_rx_data == CMD_R);

    assign w_last_byte    = (r_byte_idx == IDX_LAST);
    assign w_wr_halt      = (r_inst_data[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
    assign w_wr_last_addr = &r_inst_addr;
    assign w_cnt_sat      = &r_cycle_count;

    // Loading ends on the cycle the final (HALT or top-of-memory) word is strobed.
    assign w_load_exit = r_inst_wr_en && (w_wr_halt || w_wr_last_addr);

    always_comb begin
        w_word_next = r_word;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_byte_idx == IDXW'(k)) begin
                w_word_next[8*k +: 8] = i_rx_data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state         <= S_IDLE;
            r_word          <= '0;
            r_byte_idx      <= '0;
            r_wr_addr       <= '0;
            r_inst_wr_en    <= 1'b0;
            r_inst_addr     <= '0;
            r_inst_data     <= '0;
            r_pipe_reset    <= 1'b0;
            r_pipe_enable   <= 1'b0;
            r_cycle_count   <= '0;
            r_load_overflow <= 1'b0;
            r_finish        <= 1'b0;
        end else begin
            r_inst_wr_en  <= 1'b0;
            r_pipe_reset  <= 1'b0;
            r_pipe_enable <= 1'b0;

            if (r_pipe_enable && !w_cnt_sat) begin
                r_cycle_count <= r_cycle_count + CNT_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_l) begin
                        r_state         <= S_LOAD;
                        r_wr_addr       <= '0;
                        r_byte_idx      <= '0;
                        r_load_overflow <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (w_load_exit) begin
                        r_state <= S_READY;
                        if (!w_wr_halt) begin
                            r_load_overflow <= 1'b1;
                        end
                    end else if (i_rx_valid) begin
                        if (w_last_byte) begin
                            r_byte_idx   <= '0;
                            r_inst_wr_en <= 1'b1;
                            r_inst_addr  <= r_wr_addr;
                            r_inst_data  <= w_word_next;
                            r_wr_addr    <= r_wr_addr + ADDR_ONE;
                        end else begin
                            r_byte_idx <= r_byte_idx + IDX_ONE;
                            r_word     <= w_word_next;
                        end
                    end
                end

                S_READY: begin
                    if (w_cmd_c || w_cmd_s) begin
                        r_pipe_reset  <= 1'b1;
                        r_cycle_count <= '0;
                        r_state       <= w_cmd_c ? S_RUN_CONT : S_RUN_STEP;
                    end
                end

                S_RUN_CONT: begin
                    if (i_halt) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end else begin
                        r_pipe_enable <= 1'b1;
                    end
                end

                S_RUN_STEP: begin
                    // A halt sampled alongside a step request suppresses the step.
                    if (i_halt) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end else if (w_cmd_c) begin
                        r_state       <= S_RUN_CONT;
                        r_pipe_enable <= 1'b1;
                    end else if (w_cmd_n) begin
                        r_pipe_enable <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (w_cmd_r) begin
                        r_state       <= S_READY;
                        r_finish      <= 1'b0;
                        r_cycle_count <= '0;
                    end else if (w_cmd_l) begin
                        r_state         <= S_LOAD;
                        r_finish        <= 1'b0;
                        r_cycle_count   <= '0;
                        r_wr_addr       <= '0;
                        r_byte_idx      <= '0;
                        r_load_overflow <= 1'b0;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_inst_wr_en    = r_inst_wr_en;
    assign o_inst_addr     = r_inst_addr;
    assign o_inst_data     = r_inst_data;
    assign o_pipe_reset    = r_pipe_reset;
    assign o_pipe_enable   = r_pipe_enable;
    assign o_cycle_count   = r_cycle_count;
    assign o_load_overflow = r_load_overflow;
    assign o_finish        = r_finish;
    assign o_state         = r_state;

endmodule
